// File: rtl/kbd_seg_scan_pkg.sv
// Shared constants for the keyboard seven-segment display stage:
// digit slots, blank patterns and the active-low {g..a} hex glyph table.
package kbd_disp_pkg;

    localparam int NDIGITS = 6;

    typedef enum logic [2:0] {
        D_CNT_LO = 3'd0,
        D_CNT_HI = 3'd1,
        D_ASC_LO = 3'd2,
        D_ASC_HI = 3'd3,
        D_KEY_LO = 3'd4,
        D_KEY_HI = 3'd5
    } digit_e;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [5:0] AN_OFF    = 6'b111111;

    // Index = nibble value; lower-case b and d keep them distinct from 8 and 0.
    localparam logic [6:0] GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/kbd_seg_scan_if.sv
// Bundle between the keyboard front end and the display stage: input
// codes from upstream and the multiplexed anode/segment drive.
interface kbd_seg_scan_if;

    logic [7:0] key;
    logic [7:0] ascii;
    logic [7:0] count;
    logic       is_press;
    logic [5:0] seg_an;
    logic [7:0] seg_out;

    modport master (
        output key, ascii, count, is_press,
        input  seg_an, seg_out
    );

    modport slave (
        input  key, ascii, count, is_press,
        output seg_an, seg_out
    );

endinterface

// File: rtl/kbd_seg_scan_nibble.sv
// Combinational hex nibble to active-low {g,f,e,d,c,b,a} segment decoder.
module kbd_seg_nibble
    import kbd_disp_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = GLYPH[nib];

endmodule

// File: rtl/kbd_seg_scan.sv
// Six-digit multiplexed display of key/ascii/count with a frame-atomic
// input snapshot, blanking when no key is held and a press flash on dp.
module kbd_seg_scan
    import kbd_disp_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int FLASH_FRAMES = 16
)
(
    input  logic           clk,
    input  logic           rst,
    kbd_seg_scan_if.slave  bus
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int FW = $clog2(FLASH_FRAMES + 2);

    logic [DW-1:0]      div_q, div_d;
    digit_e             idx_q, idx_d;
    logic [7:0]         key_snap_q, key_snap_d;
    logic [7:0]         asc_snap_q, asc_snap_d;
    logic [7:0]         cnt_snap_q, cnt_snap_d;
    logic               press_snap_q, press_snap_d;
    logic               press_hist_q, press_hist_d;
    logic [FW-1:0]      flash_q, flash_d;
    logic [NDIGITS-1:0] seg_an_q, seg_an_d;
    logic [7:0]         seg_out_q, seg_out_d;

    logic       tick, frame_start, rise;
    logic [7:0] src_key, src_asc, src_cnt;
    logic       src_press;
    logic [3:0] nib;
    logic [6:0] glyph;

    kbd_seg_nibble u_nibble (
        .nib (nib),
        .seg (glyph)
    );

    always_comb begin
        tick        = (div_q == DW'(SCAN_DIV - 1));
        div_d       = tick ? '0 : div_q + 1'b1;
        idx_d       = idx_q;
        if (tick) begin
            idx_d = (idx_q == D_KEY_HI) ? D_CNT_LO : digit_e'(idx_q + 3'd1);
        end
        frame_start = tick && (idx_q == D_KEY_HI);

        // Digit 0 of a new frame must show the values being captured now.
        src_key   = frame_start ? bus.key      : key_snap_q;
        src_asc   = frame_start ? bus.ascii    : asc_snap_q;
        src_cnt   = frame_start ? bus.count    : cnt_snap_q;
        src_press = frame_start ? bus.is_press : press_snap_q;

        key_snap_d   = src_key;
        asc_snap_d   = src_asc;
        cnt_snap_d   = src_cnt;
        press_snap_d = src_press;

        rise         = bus.is_press && !press_hist_q;
        press_hist_d = bus.is_press;
        flash_d      = flash_q;
        if (rise) begin
            flash_d = FW'(FLASH_FRAMES);
        end else if (frame_start && (flash_q != '0)) begin
            flash_d = flash_q - 1'b1;
        end

        case (idx_d)
            D_CNT_LO: nib = src_cnt[3:0];
            D_CNT_HI: nib = src_cnt[7:4];
            D_ASC_LO: nib = src_asc[3:0];
            D_ASC_HI: nib = src_asc[7:4];
            D_KEY_LO: nib = src_key[3:0];
            default:  nib = src_key[7:4];
        endcase

        seg_an_d  = seg_an_q;
        seg_out_d = seg_out_q;
        if (tick) begin
            if (!src_press && (idx_d >= D_ASC_LO)) begin
                seg_an_d  = AN_OFF;
                seg_out_d = SEG_BLANK;
            end else begin
                seg_an_d  = ~(6'd1 << idx_d);
                seg_out_d = {!((idx_d == D_CNT_LO) && (flash_q != '0)), glyph};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q        <= '0;
            idx_q        <= D_KEY_HI;
            key_snap_q   <= '0;
            asc_snap_q   <= '0;
            cnt_snap_q   <= '0;
            press_snap_q <= 1'b0;
            press_hist_q <= 1'b0;
            flash_q      <= '0;
            seg_an_q     <= AN_OFF;
            seg_out_q    <= SEG_BLANK;
        end else begin
            div_q        <= div_d;
            idx_q        <= idx_d;
            key_snap_q   <= key_snap_d;
            asc_snap_q   <= asc_snap_d;
            cnt_snap_q   <= cnt_snap_d;
            press_snap_q <= press_snap_d;
            press_hist_q <= press_hist_d;
            flash_q      <= flash_d;
            seg_an_q     <= seg_an_d;
            seg_out_q    <= seg_out_d;
        end
    end

    assign bus.seg_an  = seg_an_q;
    assign bus.seg_out = seg_out_q;

endmodule

// File: tb/tb_kbd_seg_scan.sv
// Directed-plus-random bench for kbd_seg_scan against a frame/tick
// arithmetic model of the display timing and glyph drawing.
module tb_kbd_seg_scan;

    localparam int SD = 4;
    localparam int FL = 2;

    logic clk = 1'b0;
    logic rst;
    kbd_seg_scan_if bus ();

    kbd_seg_scan #(.SCAN_DIV(SD), .FLASH_FRAMES(FL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Lit segments of each hex glyph.
    string seg_names [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg",
                              "acdefg", "abc", "abcdefg", "abcdfg", "abcefg",
                              "cdefg", "adef", "bcdeg", "adefg", "aefg"};

    int         m_e;
    int         m_digit;
    bit         m_tick;
    logic [7:0] s_key, s_asc, s_cnt;
    bit         s_press;
    bit         m_prev;
    int         m_flash;
    logic [5:0] m_an;
    logic [7:0] m_out;

    function automatic logic [6:0] glyph(input int n);
        logic [6:0] r;
        string      s;
        r = 7'h7F;
        s = seg_names[n];
        for (int i = 0; i < s.len(); i++) r[int'(s[i]) - 97] = 1'b0;
        return r;
    endfunction

    task automatic model_edge();
        bit rise, fs;
        int byte_v, nib;
        if (rst) begin
            m_e = 0; m_tick = 0; m_digit = 5;
            s_key = 0; s_asc = 0; s_cnt = 0; s_press = 0;
            m_prev = 0; m_flash = 0;
            m_an = 6'h3F; m_out = 8'hFF;
            return;
        end
        m_e++;
        m_tick = (m_e % SD == 0);
        rise = bus.is_press && !m_prev;
        fs = 0;
        if (m_tick) begin
            m_digit = (m_e / SD - 1) % 6;
            fs = (m_digit == 0);
            if (fs) begin
                s_key = bus.key; s_asc = bus.ascii; s_cnt = bus.count; s_press = bus.is_press;
            end
            case (m_digit / 2)
                0: byte_v = s_cnt;
                1: byte_v = s_asc;
                default: byte_v = s_key;
            endcase
            nib = (m_digit % 2 == 1) ? byte_v / 16 : byte_v % 16;
            if (m_digit >= 2 && !s_press) begin
                m_an = 6'h3F; m_out = 8'hFF;
            end else begin
                m_an = 6'h3F;
                m_an[m_digit] = 1'b0;
                m_out = {~(m_digit == 0 && m_flash != 0), glyph(nib)};
            end
        end
        if (rise) m_flash = FL;
        else if (fs && m_flash > 0) m_flash--;
        m_prev = bus.is_press;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        n_cmp++;
        assert (bus.seg_an === m_an) else begin
            n_bad++;
            $error("FAIL seg_an e=%0d observed=%h expected=%h", m_e, bus.seg_an, m_an);
        end
        n_cmp++;
        assert (bus.seg_out === m_out) else begin
            n_bad++;
            $error("FAIL seg_out e=%0d observed=%h expected=%h", m_e, bus.seg_out, m_out);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_until_digit(input int d);
        bit found;
        found = 0;
        for (int i = 0; i < 7 * SD && !found; i++) begin
            step();
            found = m_tick && (m_digit == d);
        end
        n_cmp++;
        assert (found) else begin
            n_bad++;
            $error("FAIL wait_digit observed=timeout expected=digit %0d", d);
        end
    endtask

    task automatic check_const(input string tag, input logic [5:0] an, input logic [7:0] so);
        n_cmp++;
        assert (bus.seg_an === an && bus.seg_out === so) else begin
            n_bad++;
            $error("FAIL %s observed=%h/%h expected=%h/%h", tag, bus.seg_an, bus.seg_out, an, so);
        end
    endtask

    initial begin
        bit found;
        rst = 1'b1;
        bus.key = 8'h00; bus.ascii = 8'h00; bus.count = 8'h00; bus.is_press = 1'b0;
        run(2);
        check_const("reset", 6'h3F, 8'hFF);
        rst = 1'b0;

        // Release: blank for SCAN_DIV-1 cycles, then count low digit "0".
        for (int i = 0; i < SD - 1; i++) begin
            step();
            check_const("release_blank", 6'h3F, 8'hFF);
        end
        step();
        check_const("first_digit", 6'b111110, 8'hC0);

        bus.key = 8'h1C; bus.ascii = 8'h61; bus.count = 8'h05; bus.is_press = 1'b1;
        run(12 * SD);

        bus.is_press = 1'b0;
        run(12 * SD);

        // Mid-frame key change stays out of the current frame.
        bus.is_press = 1'b1;
        run_until_digit(2);
        step();
        bus.key = 8'h32;
        run(12 * SD);

        // Press flash, then a re-press coinciding with a frame start.
        bus.is_press = 1'b0;
        run(6 * SD);
        run_until_digit(3);
        bus.is_press = 1'b1;
        run_until_digit(3);
        bus.is_press = 1'b0;
        step();
        found = 0;
        for (int i = 0; i < 7 * SD && !found; i++) begin
            if ((m_e + 1) % (6 * SD) == SD) found = 1;
            else step();
        end
        n_cmp++;
        assert (found) else begin
            n_bad++;
            $error("FAIL wait_frame_start observed=timeout expected=edge");
        end
        bus.is_press = 1'b1;
        step();
        run(18 * SD);

        // Reset pulse while digit 3 is showing.
        run_until_digit(3);
        step();
        rst = 1'b1;
        step();
        check_const("mid_reset", 6'h3F, 8'hFF);
        rst = 1'b0;
        bus.key = 8'hA7; bus.ascii = 8'hDB; bus.count = 8'hE9;
        run(12 * SD);

        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                bus.key      = 8'($urandom);
                bus.ascii    = 8'($urandom);
                bus.count    = 8'($urandom);
                bus.is_press = 1'($urandom);
            end
            rst = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
